// File: rtl/sd_spi_responder_if.sv
// sd_spi_responder_if: SPI link plus block-memory read port between the host side and the SD card responder.
interface sd_spi_responder_if;
  logic spi_cs;
  logic spi_clk;
  logic spi_mosi;
  logic spi_miso;
  logic [8:0] mem_rd_addr;
  logic [7:0] mem_rd_data;
  logic [31:0] blk_addr;
  logic card_idle;
  logic busy_rd;
  modport master (
    output spi_cs, spi_clk, spi_mosi, mem_rd_data,
    input spi_miso, mem_rd_addr, blk_addr, card_idle, busy_rd
  );
  modport slave (
    input spi_cs, spi_clk, spi_mosi, mem_rd_data,
    output spi_miso, mem_rd_addr, blk_addr, card_idle, busy_rd
  );
endinterface

// File: rtl/sd_spi_responder.sv
// sd_spi_responder: SPI-mode SD card model answering init commands and streaming CMD17 blocks from a byte memory.
module sd_spi_responder #(
  parameter int NCR = 1,
  parameter int NAC = 2,
  parameter int INIT_RETRIES = 2
) (
  input logic iclk,
  input logic rst,
  sd_spi_responder_if.slave bus
);
  typedef enum logic [2:0] {ST_RX, ST_NCR, ST_RESP, ST_NAC, ST_TOKEN, ST_DATA, ST_CRC} state_t;
  state_t state, state_nxt;
  logic [1:0] cs_s, mosi_s;
  logic [2:0] sck_s;
  logic cs_q, cs_rise, rise, fall, byte_done;
  logic [2:0] cnt;
  logic [9:0] n;
  logic [6:0] rx_sh;
  logic [7:0] rx_byte, tx_sh, tx_byte, r1, retry;
  logic [37:0] frame;
  logic [5:0] idx;
  logic miso, idle, app, r7, rd, busy;
  logic [8:0] rd_addr;
  logic [31:0] blk;
  assign cs_rise = cs_s[1] & ~cs_q;
  assign rise = ~cs_s[1] & sck_s[1] & ~sck_s[2];
  assign fall = ~cs_s[1] & ~sck_s[1] & sck_s[2];
  assign byte_done = rise & (cnt == 3'd7);
  assign rx_byte = {rx_sh, mosi_s[1]};
  assign idx = frame[37:32];
  assign bus.spi_miso = miso;
  assign bus.mem_rd_addr = rd_addr;
  assign bus.blk_addr = blk;
  assign bus.card_idle = idle;
  assign bus.busy_rd = busy;
  always_ff @(posedge iclk) begin
    if (rst) begin
      cs_s <= 2'b11;
      cs_q <= 1'b1;
      sck_s <= 3'b000;
      mosi_s <= 2'b11;
    end else begin
      cs_s <= {cs_s[0], bus.spi_cs};
      cs_q <= cs_s[1];
      sck_s <= {sck_s[1:0], bus.spi_clk};
      mosi_s <= {mosi_s[0], bus.spi_mosi};
    end
  end
  always_ff @(posedge iclk) state <= rst ? ST_RX : state_nxt;
  // tx_byte is the byte that goes out next, loaded on the falling edge after a byte completes
  always_comb begin
    state_nxt = state;
    tx_byte = 8'hFF;
    case (state)
      ST_RX: if (byte_done && n == 10'd5) state_nxt = ST_NCR;
      ST_NCR: if (byte_done && n == 10'(NCR - 1)) state_nxt = ST_RESP;
      ST_RESP: begin
        tx_byte = n == 10'd0 ? r1 : n == 10'd3 ? 8'h01 : n == 10'd4 ? frame[7:0] : 8'h00;
        if (byte_done && !(r7 && n < 10'd4)) state_nxt = rd ? ST_NAC : ST_RX;
      end
      ST_NAC: if (byte_done && n == 10'(NAC - 1)) state_nxt = ST_TOKEN;
      ST_TOKEN: begin
        tx_byte = 8'hFE;
        if (byte_done) state_nxt = ST_DATA;
      end
      ST_DATA: begin
        tx_byte = bus.mem_rd_data;
        if (byte_done && n == 10'd511) state_nxt = ST_CRC;
      end
      ST_CRC: if (byte_done && n == 10'd1) state_nxt = ST_RX;
      default: state_nxt = ST_RX;
    endcase
    if (cs_rise) state_nxt = ST_RX;
  end
  always_ff @(posedge iclk) begin
    if (rst) begin
      cnt <= 3'd0;
      n <= 10'd0;
      rx_sh <= 7'd0;
      tx_sh <= 8'hFF;
      miso <= 1'b1;
      frame <= '0;
      r1 <= 8'hFF;
      r7 <= 1'b0;
      rd <= 1'b0;
      idle <= 1'b1;
      app <= 1'b0;
      retry <= 8'd0;
      rd_addr <= 9'd0;
      blk <= 32'd0;
      busy <= 1'b0;
    end else if (cs_rise) begin
      cnt <= 3'd0;
      n <= 10'd0;
      tx_sh <= 8'hFF;
      miso <= 1'b1;
      busy <= 1'b0;
    end else begin
      if (rise) begin
        cnt <= cnt + 3'd1;
        rx_sh <= rx_byte[6:0];
      end
      if (fall) begin
        miso <= cnt == 3'd0 ? tx_byte[7] : tx_sh[7];
        tx_sh <= cnt == 3'd0 ? {tx_byte[6:0], 1'b1} : {tx_sh[6:0], 1'b1};
        if (cnt == 3'd0 && state == ST_DATA) rd_addr <= rd_addr + 9'd1;
      end
      if (byte_done) begin
        // n counts bytes within the current phase; in RX it only runs once a 01xxxxxx start byte is seen
        n <= (state != state_nxt || (state == ST_RX && n == 10'd0 && rx_byte[7:6] != 2'b01)) ? 10'd0 : n + 10'd1;
        if (state == ST_RX && n != 10'd5) frame <= {frame[29:0], rx_byte};
        if (state == ST_NAC && state_nxt == ST_TOKEN) rd_addr <= 9'd0;
        if (state == ST_CRC && n == 10'd1) busy <= 1'b0;
        if (state == ST_RX && n == 10'd5) begin
          r7 <= idx == 6'd8;
          rd <= 1'b0;
          app <= idx == 6'd55;
          case (idx)
            6'd0: begin
              r1 <= 8'h01;
              idle <= 1'b1;
              retry <= 8'd0;
            end
            6'd8: r1 <= 8'h01;
            6'd55: r1 <= {7'd0, idle};
            6'd41: begin
              if (!app) r1 <= {5'd0, 2'b10, idle};
              else if (retry < 8'(INIT_RETRIES)) begin
                r1 <= 8'h01;
                retry <= retry + 8'd1;
              end else begin
                r1 <= 8'h00;
                idle <= 1'b0;
              end
            end
            6'd17: begin
              r1 <= idle ? 8'h05 : 8'h00;
              rd <= ~idle;
              if (!idle) begin
                blk <= frame[31:0];
                busy <= 1'b1;
              end
            end
            default: r1 <= {5'd0, 2'b10, idle};
          endcase
        end
      end
    end
  end
endmodule

// File: tb/tb_sd_spi_responder.sv
// tb_sd_spi_responder: SPI host driving the card model, checked against a command-level model of the SD responder.
module tb_sd_spi_responder;
  localparam int NCR = 1;
  localparam int NAC = 2;
  localparam int RETRIES = 2;
  localparam int H = 3;
  typedef struct {
    logic [5:0] idx;
    logic [31:0] arg;
    logic [7:0] r1;
    logic idle;
  } vec_t;
  logic iclk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  logic [7:0] mem [512];
  logic [7:0] expq[$];
  logic [7:0] gotq[$];
  logic busyq[$];
  logic m_idle = 1'b1;
  logic m_app = 1'b0;
  int m_retry = 0;
  int steps = 0;
  int addr_err = 0;
  logic [8:0] prev_addr = 9'd0;

  sd_spi_responder_if bus();
  sd_spi_responder #(.NCR(NCR), .NAC(NAC), .INIT_RETRIES(RETRIES)) dut (.iclk(iclk), .rst(rst), .bus(bus));

  always #5 iclk = ~iclk;
  always @(posedge iclk) bus.mem_rd_data <= mem[bus.mem_rd_addr];
  always @(negedge iclk) begin
    if (bus.mem_rd_addr != prev_addr) begin
      steps++;
      if (bus.mem_rd_addr != 9'(prev_addr + 9'd1) && bus.mem_rd_addr != 9'd0) addr_err++;
    end
    prev_addr = bus.mem_rd_addr;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick(input int c);
    repeat (c) @(negedge iclk);
  endtask

  task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
    for (int i = 7; i >= 0; i--) begin
      bus.spi_mosi = tx[i];
      tick(H);
      rx[i] = bus.spi_miso;
      bus.spi_clk = 1'b1;
      tick(H);
      bus.spi_clk = 1'b0;
    end
  endtask

  task automatic send_cmd(input logic [5:0] idx, input logic [31:0] arg);
    logic [7:0] d;
    xfer({2'b01, idx}, d);
    for (int i = 3; i >= 0; i--) xfer(arg[8*i +: 8], d);
    xfer(8'h95, d);
  endtask

  // Expected host-visible byte stream for one command, straight from the card's command rules
  task automatic model_cmd(input logic [5:0] idx, input logic [31:0] arg);
    logic was_app;
    was_app = m_app;
    m_app = idx == 6'd55;
    expq.delete();
    repeat (NCR) expq.push_back(8'hFF);
    if (idx == 6'd0) begin
      m_idle = 1'b1;
      m_retry = 0;
      expq.push_back(8'h01);
    end else if (idx == 6'd8) begin
      expq.push_back(8'h01);
      expq.push_back(8'h00);
      expq.push_back(8'h00);
      expq.push_back(8'h01);
      expq.push_back(arg[7:0]);
    end else if (idx == 6'd55) begin
      expq.push_back(m_idle ? 8'h01 : 8'h00);
    end else if (idx == 6'd41 && was_app) begin
      if (m_retry < RETRIES) begin
        expq.push_back(8'h01);
        m_retry++;
      end else begin
        expq.push_back(8'h00);
        m_idle = 1'b0;
      end
    end else if (idx == 6'd17 && !m_idle) begin
      expq.push_back(8'h00);
      repeat (NAC) expq.push_back(8'hFF);
      expq.push_back(8'hFE);
      for (int k = 0; k < 512; k++) expq.push_back(mem[k]);
      expq.push_back(8'hFF);
      expq.push_back(8'hFF);
    end else begin
      expq.push_back(m_idle ? 8'h05 : 8'h04);
    end
    expq.push_back(8'hFF);
  endtask

  task automatic read_check(input string name, input int n);
    logic [7:0] b;
    int bad;
    bad = -1;
    gotq.delete();
    busyq.delete();
    for (int k = 0; k < n; k++) begin
      xfer(8'hFF, b);
      gotq.push_back(b);
      busyq.push_back(bus.busy_rd);
      if (bad < 0 && b !== expq[k]) bad = k;
    end
    checks++;
    if (bad >= 0) begin
      failures++;
      $display("FAIL %s: byte %0d got %h expected %h", name, bad, gotq[bad], expq[bad]);
    end
  endtask

  task automatic run_cmd(input string name, input logic [5:0] idx, input logic [31:0] arg);
    model_cmd(idx, arg);
    send_cmd(idx, arg);
    read_check(name, expq.size());
  endtask

  initial begin
    vec_t tbl [14];
    logic [5:0] picks [8];
    logic [7:0] d;
    logic [31:0] a;
    logic [5:0] ri;
    int base, nbad;
    tbl = '{
      '{6'd41, 32'h0, 8'h05, 1'b1},
      '{6'd17, 32'h0, 8'h05, 1'b1},
      '{6'd0, 32'h0, 8'h01, 1'b1},
      '{6'd8, 32'h000001AA, 8'h01, 1'b1},
      '{6'd55, 32'h0, 8'h01, 1'b1},
      '{6'd41, 32'h40000000, 8'h01, 1'b1},
      '{6'd55, 32'h0, 8'h01, 1'b1},
      '{6'd41, 32'h40000000, 8'h01, 1'b1},
      '{6'd55, 32'h0, 8'h01, 1'b1},
      '{6'd41, 32'h40000000, 8'h00, 1'b0},
      '{6'd5, 32'h0, 8'h04, 1'b0},
      '{6'd41, 32'h0, 8'h04, 1'b0},
      '{6'd55, 32'h0, 8'h00, 1'b0},
      '{6'd8, 32'h0000015A, 8'h01, 1'b0}
    };
    picks = '{6'd0, 6'd8, 6'd55, 6'd41, 6'd55, 6'd41, 6'd17, 6'd8};
    bus.spi_cs = 1'b1;
    bus.spi_clk = 1'b0;
    bus.spi_mosi = 1'b1;
    for (int i = 0; i < 512; i++) mem[i] = 8'(i);
    tick(4);
    rst = 1'b0;
    tick(2);
    chk("reset_miso", bus.spi_miso, 1);
    chk("reset_addr", bus.mem_rd_addr, 0);
    chk("reset_blk", bus.blk_addr, 0);
    chk("reset_idle", bus.card_idle, 1);
    chk("reset_busy", bus.busy_rd, 0);
    // Wakeup clocks and a CMD55 frame with cs high must leave no trace
    nbad = 0;
    for (int i = 0; i < 10; i++) begin
      xfer(8'hFF, d);
      if (d !== 8'hFF) nbad++;
    end
    send_cmd(6'd55, 32'h0);
    chk("wakeup_miso", nbad, 0);
    chk("wakeup_idle", bus.card_idle, 1);
    bus.spi_cs = 1'b0;
    tick(4);
    for (int i = 0; i < 14; i++) begin
      run_cmd($sformatf("tbl%0d_stream", i), tbl[i].idx, tbl[i].arg);
      chk($sformatf("tbl%0d_r1", i), gotq[NCR], tbl[i].r1);
      chk($sformatf("tbl%0d_idle", i), bus.card_idle, tbl[i].idle);
    end
    base = steps;
    run_cmd("cmd17_block", 6'd17, 32'h00001234);
    chk("cmd17_blk_addr", bus.blk_addr, 32'h00001234);
    nbad = 0;
    for (int k = 0; k < expq.size() - 2; k++) if (busyq[k] !== 1'b1) nbad++;
    chk("cmd17_busy_during", nbad, 0);
    chk("cmd17_busy_after", busyq[expq.size() - 2], 0);
    chk("cmd17_addr_steps", steps - base, 512);
    chk("cmd17_addr_order", addr_err, 0);
    // Deassert cs at data byte 100, then a fresh read must restart at byte 0
    for (int i = 0; i < 512; i++) mem[i] = 8'($urandom);
    a = $urandom;
    model_cmd(6'd17, a);
    send_cmd(6'd17, a);
    read_check("abort_prefix", NCR + NAC + 2 + 100);
    bus.spi_cs = 1'b1;
    tick(6);
    chk("abort_miso", bus.spi_miso, 1);
    chk("abort_busy", bus.busy_rd, 0);
    nbad = 0;
    for (int i = 0; i < 2; i++) begin
      xfer(8'hFF, d);
      if (d !== 8'hFF) nbad++;
    end
    chk("abort_cs_high_miso", nbad, 0);
    chk("abort_keep_idle", bus.card_idle, 0);
    chk("abort_keep_blk", bus.blk_addr, a);
    bus.spi_cs = 1'b0;
    tick(4);
    a = $urandom;
    model_cmd(6'd17, a);
    send_cmd(6'd17, a);
    read_check("fresh_block_head", NCR + NAC + 2 + 40);
    chk("fresh_blk_addr", bus.blk_addr, a);
    bus.spi_cs = 1'b1;
    tick(6);
    bus.spi_cs = 1'b0;
    tick(4);
    // Reset mid-block returns the card to its power-on state
    a = $urandom;
    model_cmd(6'd17, a);
    send_cmd(6'd17, a);
    read_check("rst_prefix", NCR + NAC + 2 + 50);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    m_idle = 1'b1;
    m_app = 1'b0;
    m_retry = 0;
    tick(2);
    chk("rst_idle", bus.card_idle, 1);
    chk("rst_busy", bus.busy_rd, 0);
    chk("rst_blk", bus.blk_addr, 0);
    chk("rst_miso", bus.spi_miso, 1);
    chk("rst_addr", bus.mem_rd_addr, 0);
    run_cmd("post_rst_cmd17", 6'd17, 32'h55);
    chk("post_rst_r1", gotq[NCR], 8'h05);
    for (int i = 0; i < 25; i++) begin
      ri = picks[$urandom_range(0, 7)];
      if ($urandom_range(0, 3) == 0) ri = 6'($urandom_range(0, 63));
      if (ri == 6'd17 && !m_idle) ri = 6'd8;
      a = $urandom;
      run_cmd($sformatf("rand%0d_cmd%0d", i, ri), ri, a);
      chk($sformatf("rand%0d_idle", i), bus.card_idle, m_idle);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sd_spi_responder.md
Name: sd_spi_responder

Overview:
- SPI-mode SD card responder: the card end of the link driven by our SD host controller.
- Used as a synthesizable card model for bench and board loopback, so the host's init and read microcode runs without a physical card.
- Decodes 6-byte commands CMD0, CMD8, CMD55, ACMD41 and CMD17, and returns R1/R7 responses.
- For CMD17, streams a 512-byte block from an external byte memory, framed by a start token and CRC bytes.

Parameters:
- NCR, 1: number of 0xFF bytes between the last command byte and the R1 byte (range 1..8).
- NAC, 2: number of 0xFF bytes between the CMD17 R1 byte and the 0xFE token (range 1..16).
- INIT_RETRIES, 2: number of ACMD41 polls answered 0x01 before the card answers 0x00.

Ports:
- iclk  in  1  system clock; every register in the block is clocked on it.
- rst  in  1  synchronous, active-high reset.
- spi_cs  in  1  chip select, active low, asynchronous to iclk.
- spi_clk  in  1  SPI clock, mode 0, asynchronous; its frequency is at most iclk/4.
- spi_mosi  in  1  host to card data, MSB first.
- spi_miso  out  1  card to host data, MSB first; driven 1 when idle (never tristated).
- mem_rd_addr  out  9  byte index within the block being read.
- mem_rd_data  in  8  byte at mem_rd_addr, valid exactly 1 iclk after the address changes.
- blk_addr  out  32  CMD17 argument, latched when CMD17 is accepted.
- card_idle  out  1  SD idle-state flag (R1 bit 0).
- busy_rd  out  1  high from CMD17 acceptance through the last CRC byte.

Behaviour:
- Reset values: spi_miso=1, mem_rd_addr=0, blk_addr=0, card_idle=1, busy_rd=0; app flag=0, retry count=0; FSM=RX, bit count=0.
- Input sync and edge detect:
  - spi_cs, spi_clk and spi_mosi each pass through a 2-flop synchronizer; edges are detected on the synchronized spi_clk.
  - A rising edge samples spi_mosi into the shift register.
  - A falling edge shifts the next output bit onto spi_miso.
  - spi_clk edges are ignored while spi_cs is high.
- Byte framing:
  - A 3-bit counter completes a byte on the 8th rising edge.
  - The next output byte is loaded at the following falling edge; its MSB appears then.
- FSM states and transitions:
  - RX: collect bytes. A byte with [7:6]=01 starts a frame; all other bytes are discarded. After 6 bytes → NCR.
    - index = byte0[5:0]; arg = bytes 1..4, big-endian; the CRC byte is ignored.
  - NCR: output 0xFF for NCR bytes → RESP.
  - RESP: output R1, plus 4 extra bytes for R7 → RX, or → NAC for an accepted CMD17.
  - NAC: output 0xFF for NAC bytes → TOKEN.
  - TOKEN: output 0xFE → DATA.
  - DATA: output 512 bytes → CRC.
  - CRC: output 0xFF, 0xFF → RX; busy_rd=0.
- Command decode. app flag = ACMD prefix flag, set by CMD55 and cleared by any other command:
  - CMD0: card_idle=1, retry count=0; R1=0x01.
  - CMD8: R7 = 0x01, 0x00, 0x00, 0x01, arg[7:0] (echo of the check pattern).
  - CMD55: R1={7'b0,card_idle}; set app flag.
  - ACMD41 (index 41 with app flag set):
    - while retry count < INIT_RETRIES: R1=0x01 and retry count increments;
    - otherwise R1=0x00 and card_idle=0.
    - The app flag clears after the command.
  - CMD41 without the app flag, or any other index: R1={5'b0,1'b1 (illegal),1'b0,card_idle}, i.e. 0x05 idle / 0x04 ready.
  - CMD17 with card_idle=1: R1=0x05 and no data phase.
  - CMD17 with card_idle=0: R1=0x00; latch blk_addr=arg; busy_rd=1.
- Data fetch:
  - mem_rd_addr=0 on entry to TOKEN.
  - Each data byte loads mem_rd_data into the output shifter.
  - mem_rd_addr increments right after each load; it wraps 511→0, and that wrap is unused.
- MOSI during the response, NAC, token, data and CRC phases is ignored (the host sends 0xFF); no command can be detected until the FSM returns to RX.
- spi_cs rising (deassert) in any state:
  - FSM→RX, bit count=0, spi_miso=1, busy_rd=0;
  - card_idle, app flag, retry count and blk_addr are retained.
- rst asserted mid-transfer: full return to reset values on the next iclk.
- Clocks with spi_cs high (the host's 80-clock wakeup) produce no state change.

Test Plan:
- Reset, cs high, 10×0xFF → miso stays 1, FSM stays RX, card_idle=1.
- CMD0 (40 00 00 00 00 95), then 2 clocked 0xFF bytes → host reads FF, 01 (NCR=1); card_idle=1.
- CMD8 (48 00 00 01 AA 87), then 6×0xFF → FF, 01, 00, 00, 01, AA.
- CMD55 + ACMD41 loop with INIT_RETRIES=2 → ACMD41 R1 sequence 01, 01, 00; card_idle falls after the third ACMD41; CMD55 R1 = 01, 01, 01.
- CMD17 with arg 0x00001234 after init, mem preloaded with byte i = i[7:0] → R1 00, then FF, FF, FE, 00..FF twice, FF, FF.
  - blk_addr=0x00001234; busy_rd high throughout; mem_rd_addr steps 0..511.
- CMD17 before init → 05 and no token. Unknown CMD5 after init → 04.
- Deassert cs at data byte 100, reassert, send CMD17 → miso=1 while deasserted, then a full fresh block from byte 0. Asserting rst mid-block → card_idle=1 and the next CMD17 returns 05.
